aq_mem_arbiter: RTL and testbench

Shares one single-port, 64 KB synchronous byte RAM between three requesters: the Z80 CPU (slot-driven by its clock enable), the cartridge/tape download port (write-only, buffered through a small FIFO) and the tape-playback reader (req/ack reads). It sits between the CPU/PLA memory signals, the user_io download stream and the RAM macro. It replaces dedicated dual-port RAMs with a single arbitrated port. It also sequences download completion so the cartridge can be enabled only after every byte has landed.

---
 rtl/aq_mem_arbiter_if.sv | 24 ++
 rtl/aq_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_aq_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_mem_arbiter_if.sv
// RAM port bundle between the arbiter (master) and the single-port byte RAM (slave).
// mem_q is the RAM's registered read data: valid the cycle after mem_addr is presented.
interface aq_mem_arbiter_if #(
    parameter int AW = 16
);
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_q;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_q
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_q
    );
endinterface

// File: rtl/aq_mem_arbiter.sv
// Single-port RAM arbiter for the Z80 CPU, the buffered download port and the tape reader.
// One RAM slot per clk_sys cycle, fixed priority CPU > download FIFO > tape.
// The RAM-side outputs are combinational so CPU writes land in their own grant cycle.
module aq_mem_arbiter #(
    parameter int AW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          cpu_ce,
    input  logic          cpu_rd,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,

    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic          dl_busy,
    output logic          dl_done,
    output logic          dl_overflow,

    input  logic          tape_req,
    input  logic [AW-1:0] tape_addr,
    output logic          tape_ack,
    output logic [7:0]    tape_data,

    aq_mem_arbiter_if.master mem
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {T_IDLE, T_WAIT, T_DATA, T_HOLD} tape_state_t;
    typedef enum logic [1:0] {DL_IDLE, DL_ACTIVE, DL_DRAIN} dl_state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } dl_entry_t;

    tape_state_t tape_state, tape_next;
    dl_state_t   dl_state, dl_next;

    dl_entry_t   fifo_mem [FIFO_DEPTH];
    dl_entry_t   fifo_head;
    logic [PW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, fifo_push, fifo_pop, overflow_set;

    logic        cpu_grant, fifo_grant, tape_grant;
    logic        cpu_rd_pend;
    logic        dl_prev, dl_rise, dl_done_nxt, overflow_clr;

    logic [AW-1:0] mem_addr_c, mem_addr_q;
    logic [7:0]    mem_wdata_c, mem_wdata_q;
    logic          mem_we_c;

    // FIFO status; the extra pointer bit separates full from empty.
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign fifo_head    = fifo_mem[rd_ptr[PW-1:0]];
    assign fifo_pop     = fifo_grant;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign fifo_push    = ioctl_wr & (~fifo_full | fifo_pop);
    assign overflow_set = ioctl_wr & fifo_full & ~fifo_pop;

    // Fixed-priority slot grant; nothing is granted while reset is held.
    assign cpu_grant  = ~reset & cpu_ce & (cpu_rd | cpu_we);
    assign fifo_grant = ~reset & ~cpu_grant & ~fifo_empty;
    assign tape_grant = ~reset & ~cpu_grant & fifo_empty & (tape_state == T_WAIT);

    assign dl_rise = ioctl_download & ~dl_prev;
    assign dl_busy = (dl_state != DL_IDLE) | ~fifo_empty;

    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_wdata = mem_wdata_c;
    assign mem.mem_we    = mem_we_c;

    // RAM port mux: the granted requester drives the port, otherwise address/data hold.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        mem_addr_c  = mem_addr_q;
        mem_wdata_c = mem_wdata_q;
        mem_we_c    = 1'b0;
        if (cpu_grant) begin
            mem_addr_c = cpu_addr;
            if (cpu_we) begin
                mem_we_c    = 1'b1;
                mem_wdata_c = cpu_wdata;
            end
        end else if (fifo_grant) begin
            mem_addr_c  = fifo_head.addr;
            mem_wdata_c = fifo_head.data;
            mem_we_c    = 1'b1;
        end else if (tape_grant) begin
            mem_addr_c = tape_addr;
        end
    end

    // Hold registers for the idle-slot address/data and the CPU read return path.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rd_pend <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            mem_addr_q  <= mem_addr_c;
            mem_wdata_q <= mem_wdata_c;
            cpu_rd_pend <= cpu_grant & ~cpu_we;
            if (cpu_rd_pend) cpu_rdata <= mem.mem_q;
        end
    end

    // FIFO pointers; buffered bytes are discarded by reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage written at the tail.
    always_ff @(posedge clk_sys) begin
        // NOTE: storage is not reset; the pointers alone decide which entries are valid.
        if (fifo_push) fifo_mem[wr_ptr[PW-1:0]] <= '{addr: ioctl_addr, data: ioctl_data};
    end

    // Tape FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) tape_state <= T_IDLE;
        else       tape_state <= tape_next;
    end

    // Tape FSM next state: request, wait for a slot, capture, wait for request release.
    always_comb begin
        tape_next = tape_state;
        case (tape_state)
            T_IDLE: if (tape_req)   tape_next = T_WAIT;
            T_WAIT: if (tape_grant) tape_next = T_DATA;
            T_DATA:                 tape_next = T_HOLD;
            T_HOLD: if (!tape_req)  tape_next = T_IDLE;
            default:                tape_next = T_IDLE;
        endcase
    end

    // Tape return: capture RAM data one cycle after the grant and flag it with a one-cycle ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tape_ack  <= 1'b0;
            tape_data <= '0;
        end else begin
            tape_ack <= (tape_state == T_DATA);
            if (tape_state == T_DATA) tape_data <= mem.mem_q;
        end
    end

    // Download FSM state plus its registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_state    <= DL_IDLE;
            dl_prev     <= 1'b0;
            dl_done     <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            dl_state <= dl_next;
            dl_prev  <= ioctl_download;
            dl_done  <= dl_done_nxt;
            // A byte dropped in the same cycle a session starts still counts.
            if (overflow_set)      dl_overflow <= 1'b1;
            else if (overflow_clr) dl_overflow <= 1'b0;
        end
    end

    // Download FSM next state: session start, session end, wait for the FIFO to drain.
    always_comb begin
        dl_next      = dl_state;
        dl_done_nxt  = 1'b0;
        overflow_clr = 1'b0;
        case (dl_state)
            DL_IDLE: begin
                if (dl_rise) begin
                    dl_next      = DL_ACTIVE;
                    overflow_clr = 1'b1;
                end
            end
            DL_ACTIVE: if (!ioctl_download) dl_next = DL_DRAIN;
            DL_DRAIN: begin
                if (fifo_empty) begin
                    dl_next     = DL_IDLE;
                    dl_done_nxt = 1'b1;
                end
            end
            default: dl_next = DL_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aq_mem_arbiter.sv
// Scoreboard bench for aq_mem_arbiter: stimulus pushes expected RAM writes, tape
// returns and dl_done pulses; a negedge monitor pops and compares as the DUT emits them.
module tb_aq_mem_arbiter;

    localparam int AW = 16;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          cpu_ce, cpu_rd, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          ioctl_download, ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_data;
    logic          dl_busy, dl_done, dl_overflow;
    logic          tape_req, tape_ack;
    logic [AW-1:0] tape_addr;
    logic [7:0]    tape_data;

    always #5 clk_sys = ~clk_sys;

    aq_mem_arbiter_if #(.AW(AW)) mem_bus ();

    aq_mem_arbiter #(.AW(AW), .FIFO_DEPTH(4)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .cpu_ce         (cpu_ce),
        .cpu_rd         (cpu_rd),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .dl_busy        (dl_busy),
        .dl_done        (dl_done),
        .dl_overflow    (dl_overflow),
        .tape_req       (tape_req),
        .tape_addr      (tape_addr),
        .tape_ack       (tape_ack),
        .tape_data      (tape_data),
        .mem            (mem_bus.master)
    );

    // Behavioural synchronous byte RAM (read-before-write), with a preload port.
    logic [7:0]    ram [int];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [7:0]    pre_data;

    function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
        if (ram.exists(int'(a))) return ram[int'(a)];
        return 8'h00;
    endfunction

    always @(posedge clk_sys) begin
        mem_bus.mem_q <= ram_rd(mem_bus.mem_addr);
        if (mem_bus.mem_we === 1'b1) ram[int'(mem_bus.mem_addr)] = mem_bus.mem_wdata;
        if (pre_en) ram[int'(pre_addr)] = pre_data;
    end

    // Scoreboard state.
    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        wr_q [$];
    logic [7:0] tape_q [$];
    int         dl_done_exp = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write, tape ack and dl_done pulse must match the next expectation.
    always @(negedge clk_sys) begin
        if (mem_bus.mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_ram_write_addr", 32'(mem_bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("ram_write_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
                check("ram_write_data", 32'(mem_bus.mem_wdata), 32'(e.data));
            end
        end
        if (tape_ack === 1'b1) begin
            if (tape_q.size() == 0) begin
                check("unexpected_tape_ack_data", 32'(tape_data), 32'hFFFF_FFFF);
            end else begin
                check("tape_data_at_ack", 32'(tape_data), 32'(tape_q.pop_front()));
                check("fifo_writes_before_tape_ack", 32'(wr_q.size()), 32'd0);
            end
        end
        if (dl_done === 1'b1) begin
            check("dl_done_expected", 32'(dl_done_exp > 0), 32'd1);
            check("dl_done_after_last_write", 32'(wr_q.size()), 32'd0);
            if (dl_done_exp > 0) dl_done_exp--;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && dl_done_exp != 0; i++) tick();
        check("dl_done_seen", 32'(dl_done_exp), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rdata"},   32'(cpu_rdata),        32'd0);
        check({tag, "_tape_data"},   32'(tape_data),        32'd0);
        check({tag, "_tape_ack"},    32'(tape_ack),         32'd0);
        check({tag, "_dl_busy"},     32'(dl_busy),          32'd0);
        check({tag, "_dl_done"},     32'(dl_done),          32'd0);
        check({tag, "_dl_overflow"}, 32'(dl_overflow),      32'd0);
        check({tag, "_mem_we"},      32'(mem_bus.mem_we),   32'd0);
        check({tag, "_mem_addr"},    32'(mem_bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"},   32'(mem_bus.mem_wdata), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cpu_ce = 0; cpu_rd = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_data = '0;
        tape_req = 0; tape_addr = '0;
        pre_en = 0; pre_addr = '0; pre_data = '0;

        // Reset state.
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        #1 check_reset_outputs("por");

        // Preload RAM contents used by the reads.
        tick();
        pre_en = 1; pre_addr = 16'h3000; pre_data = 8'hA5;
        tick();
        pre_addr = 16'h0100; pre_data = 8'h5A;
        tick();
        pre_en = 0;

        // CPU read: address in N, cpu_rdata from N+2.
        cpu_ce = 1; cpu_rd = 1; cpu_addr = 16'h3000;
        #1;
        check("cpu_read_mem_addr", 32'(mem_bus.mem_addr), 32'h3000);
        check("cpu_read_mem_we", 32'(mem_bus.mem_we), 32'd0);
        tick();
        cpu_ce = 0; cpu_rd = 0;
        #1;
        check("cpu_rdata_not_before_n2", 32'(cpu_rdata), 32'd0);
        check("idle_mem_addr_holds", 32'(mem_bus.mem_addr), 32'h3000);
        tick();
        check("cpu_rdata_n2", 32'(cpu_rdata), 32'hA5);

        // Download burst, CPU idle.
        ioctl_download = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            ioctl_wr = 1; ioctl_addr = 16'hC000 + 16'(i); ioctl_data = 8'h10 + 8'(i);
            wr_q.push_back('{addr: 16'hC000 + 16'(i), data: 8'h10 + 8'(i)});
            tick();
        end
        ioctl_wr = 0; ioctl_download = 0; dl_done_exp = 1;
        wait_done(20);
        repeat (3) tick();
        for (int i = 0; i < 8; i++)
            check("burst_ram_byte", 32'(ram_rd(16'hC000 + 16'(i))), 32'(8'h10 + 8'(i)));
        check("burst_no_overflow", 32'(dl_overflow), 32'd0);
        check("burst_not_busy", 32'(dl_busy), 32'd0);

        // Overflow: CPU owns every slot while 6 bytes arrive; 4 buffered.
        cpu_ce = 1; cpu_rd = 1; cpu_addr = 16'h0000; ioctl_download = 1;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr = 1; ioctl_addr = 16'hD000 + 16'(i); ioctl_data = 8'h20 + 8'(i);
            if (i < 4) wr_q.push_back('{addr: 16'hD000 + 16'(i), data: 8'h20 + 8'(i)});
            tick();
        end
        ioctl_wr = 0;
        #1;
        check("overflow_set", 32'(dl_overflow), 32'd1);
        check("overflow_busy", 32'(dl_busy), 32'd1);
        check("fifo_held_under_cpu", 32'(wr_q.size()), 32'd4);
        cpu_ce = 0; cpu_rd = 0;
        repeat (6) tick();
        check("overflow_fifo_drained", 32'(wr_q.size()), 32'd0);
        check("overflow_sticky_active", 32'(dl_overflow), 32'd1);
        ioctl_download = 0; dl_done_exp = 1;
        wait_done(20);
        tick();
        check("overflow_sticky_after_done", 32'(dl_overflow), 32'd1);

        // Tape read behind two buffered bytes; new session clears overflow.
        ioctl_download = 1; cpu_ce = 1; cpu_rd = 1; cpu_addr = 16'h0000;
        ioctl_wr = 1; ioctl_addr = 16'hE000; ioctl_data = 8'h30;
        wr_q.push_back('{addr: 16'hE000, data: 8'h30});
        tape_req = 1; tape_addr = 16'h0100;
        tape_q.push_back(8'h5A);
        tick();
        ioctl_addr = 16'hE001; ioctl_data = 8'h31;
        wr_q.push_back('{addr: 16'hE001, data: 8'h31});
        #1 check("overflow_cleared_on_rise", 32'(dl_overflow), 32'd0);
        tick();
        ioctl_wr = 0;
        tick();
        cpu_ce = 0; cpu_rd = 0;          // cycle R: FIFO writes in R and R+1
        tick();
        tick();                          // R+2: tape grant
        check("tape_grant_addr", 32'(mem_bus.mem_addr), 32'h0100);
        check("tape_grant_read", 32'(mem_bus.mem_we), 32'd0);
        tick();
        check("tape_ack_not_early", 32'(tape_ack), 32'd0);
        tick();                          // R+4: ack with data
        check("tape_ack_grant_plus2", 32'(tape_ack), 32'd1);
        check("tape_data_5a", 32'(tape_data), 32'h5A);
        tape_req = 0;
        tick();
        check("tape_ack_one_cycle", 32'(tape_ack), 32'd0);
        ioctl_download = 0; dl_done_exp = 1;
        wait_done(20);

        // Priority collision: CPU write, FIFO push and tape request together.
        ioctl_download = 1;
        tick();
        cpu_ce = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 8'h77;
        tape_req = 1; tape_addr = 16'h0100;
        ioctl_wr = 1; ioctl_addr = 16'hF000; ioctl_data = 8'h44;
        wr_q.push_back('{addr: 16'h0100, data: 8'h77});
        wr_q.push_back('{addr: 16'hF000, data: 8'h44});
        tape_q.push_back(8'h77);
        #1;
        check("collision_cpu_addr", 32'(mem_bus.mem_addr), 32'h0100);
        check("collision_cpu_we", 32'(mem_bus.mem_we), 32'd1);
        tick();
        cpu_ce = 0; cpu_we = 0; ioctl_wr = 0;
        #1;
        check("collision_fifo_addr", 32'(mem_bus.mem_addr), 32'hF000);
        check("collision_fifo_we", 32'(mem_bus.mem_we), 32'd1);
        tick();
        check("collision_tape_addr", 32'(mem_bus.mem_addr), 32'h0100);
        check("collision_tape_read", 32'(mem_bus.mem_we), 32'd0);
        tick();
        tick();
        check("collision_tape_ack", 32'(tape_ack), 32'd1);
        check("collision_tape_data", 32'(tape_data), 32'h77);
        tape_req = 0;
        tick();
        ioctl_download = 0; dl_done_exp = 1;
        wait_done(20);

        // Reset while the tape FSM is in T_DATA: the read is dropped without ack.
        tick();
        tape_req = 1; tape_addr = 16'h0100;
        tick();                          // T_WAIT, granted
        tick();                          // T_DATA
        reset = 1; tape_req = 0;
        tick();
        reset = 0;
        #1;
        check("tdata_reset_no_ack", 32'(tape_ack), 32'd0);
        check("tdata_reset_tape_data", 32'(tape_data), 32'd0);
        repeat (4) tick();

        // Reset while draining with two bytes buffered: bytes discarded, no dl_done.
        ioctl_download = 1; cpu_ce = 1; cpu_rd = 1; cpu_addr = 16'h0000;
        ioctl_wr = 1; ioctl_addr = 16'hA000; ioctl_data = 8'h55;
        tick();
        ioctl_addr = 16'hA001; ioctl_data = 8'h56;
        tick();
        ioctl_wr = 0; ioctl_download = 0;
        tick();                          // DL_DRAIN, FIFO still holds 2
        check("drain_busy_before_reset", 32'(dl_busy), 32'd1);
        reset = 1; cpu_ce = 0; cpu_rd = 0;
        tick();
        reset = 0;
        #1 check_reset_outputs("drain_reset");
        repeat (8) tick();

        // Nothing left outstanding.
        check("final_writes_outstanding", 32'(wr_q.size()), 32'd0);
        check("final_tape_outstanding", 32'(tape_q.size()), 32'd0);
        check("final_dl_done_outstanding", 32'(dl_done_exp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
